// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for the serial pattern detector: configuration, serial input,
// counter control and the detector's status outputs.
interface seq_pattern_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             cfg_mealy;
  logic             clear_cnt;
  logic             in_valid;
  logic             in_bit;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic [1:0]       fsm_state;

  modport master (
    output cfg_load, cfg_pattern, cfg_overlap, cfg_mealy, clear_cnt,
           in_valid, in_bit,
    input  match, match_count, count_sat, fsm_state
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_overlap, cfg_mealy, clear_cnt,
           in_valid, in_bit,
    output match, match_count, count_sat, fsm_state
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector with overlap/non-overlap matching,
// runtime Moore/Mealy output select and a saturating match counter.
//
// state | meaning
// IDLE  | no valid bits held in history (fill == 0)
// FILL  | history partially filled (0 < fill < PAT_W)
// ARMED | history full (fill == PAT_W)
// HIT   | Moore mode only: cycle after a match, match output high
module seq_pattern_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  seq_pattern_detector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b10,
    HIT   = 2'b11
  } state_t;

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0]    FILL_ARM  = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat, hist, hist_nxt, cand;
  logic             ovl, mly;
  logic [FW-1:0]    fill, fill_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             sat;
  logic             bit_ok, hit_now;

  // A bit arriving together with a config load is dropped with the flush.
  assign bit_ok  = bus.in_valid & ~bus.cfg_load;
  assign cand    = {hist[PAT_W-2:0], bus.in_bit};
  assign hit_now = bit_ok && (fill >= FILL_ARM) && (cand == pat);
  assign cnt_inc = cnt + 1'b1;

  // Configuration registers, captured on cfg_load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat <= '0;
      ovl <= 1'b0;
      mly <= 1'b0;
    end else if (bus.cfg_load) begin
      pat <= bus.cfg_pattern;
      ovl <= bus.cfg_overlap;
      mly <= bus.cfg_mealy;
    end
  end

  // Next history/fill: flush on load or non-overlapping hit, else shift in.
  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (bus.cfg_load) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (bit_ok) begin
      if (hit_now && !ovl) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        hist_nxt = cand;
        if (fill != FILL_FULL) fill_nxt = fill + 1'b1;
      end
    end
  end

  // History shift register and fill counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
  end

  // Next state: HIT for a Moore match, otherwise follow the new fill level.
  always_comb begin
    state_nxt = ARMED;
    if (bus.cfg_load)            state_nxt = IDLE;
    else if (hit_now && !mly)    state_nxt = HIT;
    else if (fill_nxt == '0)     state_nxt = IDLE;
    else if (fill_nxt != FILL_FULL) state_nxt = FILL;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Outputs: Moore match comes from HIT, Mealy match straight from hit_now.
  always_comb begin
    bus.match       = (state == HIT) | (mly & hit_now);
    bus.fsm_state   = state;
    bus.match_count = cnt;
    bus.count_sat   = sat;
  end

  // Saturating match counter; clear takes priority over a coincident hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (bus.clear_cnt) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (hit_now && (cnt != CNT_MAX)) begin
      cnt <= cnt_inc;
      if (cnt_inc == CNT_MAX) sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: two instances (CNT_W=8 and CNT_W=2) share
// one stimulus stream and are checked every cycle against a bit-queue model.
module tb_seq_pattern_detector;
  localparam int PAT_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic cfg_load = 1'b0, cfg_overlap = 1'b0, cfg_mealy = 1'b0;
  logic clear_cnt = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;

  int n_vec = 0;
  int n_bad = 0;
  int seen  = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(8)) ifa ();
  seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(2)) ifb ();

  assign ifa.cfg_load = cfg_load;       assign ifb.cfg_load = cfg_load;
  assign ifa.cfg_pattern = cfg_pattern; assign ifb.cfg_pattern = cfg_pattern;
  assign ifa.cfg_overlap = cfg_overlap; assign ifb.cfg_overlap = cfg_overlap;
  assign ifa.cfg_mealy = cfg_mealy;     assign ifb.cfg_mealy = cfg_mealy;
  assign ifa.clear_cnt = clear_cnt;     assign ifb.clear_cnt = clear_cnt;
  assign ifa.in_valid = in_valid;       assign ifb.in_valid = in_valid;
  assign ifa.in_bit = in_bit;           assign ifb.in_bit = in_bit;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  // Model: bits received since the last flush (oldest first, at most PAT_W),
  // plus total matches since the last clear.
  bit mq[$];
  bit [PAT_W-1:0] m_pat = '0;
  bit m_ovl = 1'b0, m_mly = 1'b0, m_pulse = 1'b0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_hit();
    bit [PAT_W-1:0] w;
    if (!in_valid || cfg_load) return 1'b0;
    if (mq.size() < PAT_W - 1) return 1'b0;
    w[0] = in_bit;
    for (int k = 1; k < PAT_W; k++) w[k] = mq[mq.size() - k];
    return w == m_pat;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit h;
    if (!reset_n) begin
      mq.delete();
      m_pat = '0; m_ovl = 1'b0; m_mly = 1'b0; m_pulse = 1'b0; m_cnt = 0;
    end else begin
      h = model_hit();
      m_pulse = h && !m_mly;
      if (clear_cnt) m_cnt = 0;
      else if (h) m_cnt++;
      if (cfg_load) begin
        m_pat = cfg_pattern; m_ovl = cfg_overlap; m_mly = cfg_mealy;
        mq.delete();
        m_pulse = 1'b0;
      end else if (in_valid) begin
        mq.push_back(in_bit);
        if (mq.size() > PAT_W) void'(mq.pop_front());
        if (h && !m_ovl) mq.delete();
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    bit exp_match;
    logic [1:0] exp_state;
    exp_match = m_pulse || (m_mly && model_hit());
    if (m_pulse)                exp_state = 2'b11;
    else if (mq.size() == 0)    exp_state = 2'b00;
    else if (mq.size() < PAT_W) exp_state = 2'b01;
    else                        exp_state = 2'b10;
    chk("a_match", 32'(ifa.match), 32'(exp_match));
    chk("a_state", 32'(ifa.fsm_state), 32'(exp_state));
    chk("a_count", 32'(ifa.match_count), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
    chk("a_sat", 32'(ifa.count_sat), 32'(m_cnt >= 255));
    chk("b_match", 32'(ifb.match), 32'(exp_match));
    chk("b_state", 32'(ifb.fsm_state), 32'(exp_state));
    chk("b_count", 32'(ifb.match_count), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    chk("b_sat", 32'(ifb.count_sat), 32'(m_cnt >= 3));
    if (ifa.match) seen++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic o, input logic m);
    cfg_load = 1'b1; cfg_pattern = p; cfg_overlap = o; cfg_mealy = m;
    cyc();
    cfg_load = 1'b0;
  endtask

  task automatic clr();
    clear_cnt = 1'b1;
    cyc();
    clear_cnt = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_count", 32'(ifa.match_count), 32'd0);

    // 1: overlap, Moore, stream 1011011 -> two matches
    load(4'b1011, 1'b1, 1'b0); seen = 0;
    send_bits(8'b0101_1011, 7); idle(2);
    chk("t1_matches", 32'(seen), 32'd2);
    chk("t1_count", 32'(ifa.match_count), 32'd2);

    // 2: non-overlap -> one match
    clr(); load(4'b1011, 1'b0, 1'b0); seen = 0;
    send_bits(8'b0101_1011, 7); idle(2);
    chk("t2_matches", 32'(seen), 32'd1);
    chk("t2_count", 32'(ifa.match_count), 32'd1);

    // 3: Mealy with a 3-cycle gap between bits 2 and 3
    clr(); load(4'b1011, 1'b1, 1'b1); seen = 0;
    send(1'b1); send(1'b0); idle(3); send(1'b1);
    in_valid = 1'b1; in_bit = 1'b1; #3;
    chk("t3_mealy_comb", 32'(ifa.match), 32'd1);
    cyc(); in_valid = 1'b0; idle(1);
    chk("t3_matches", 32'(seen), 32'd1);

    // 4: all-zeros pattern, counter saturation on the narrow instance
    clr(); load(4'b0000, 1'b1, 1'b0); seen = 0;
    send_bits(8'h00, 8); idle(2);
    chk("t4_matches", 32'(seen), 32'd5);
    chk("t4_count_b", 32'(ifb.match_count), 32'd3);
    chk("t4_sat_b", 32'(ifb.count_sat), 32'd1);
    chk("t4_count_a", 32'(ifa.match_count), 32'd5);
    clr();
    chk("t4_clr_count_b", 32'(ifb.match_count), 32'd0);
    chk("t4_clr_sat_b", 32'(ifb.count_sat), 32'd0);

    // 5: mid-cycle reset after 101, then one more bit
    load(4'b1011, 1'b1, 1'b0); seen = 0;
    send_bits(8'b0000_0101, 3);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    send(1'b1); idle(1);
    chk("t5_matches", 32'(seen), 32'd0);
    chk("t5_state", 32'(ifa.fsm_state), 32'd1);

    // 6: load coinciding with a valid bit discards that bit
    load(4'b1011, 1'b1, 1'b0);
    send_bits(8'b0000_0101, 3); seen = 0;
    in_valid = 1'b1; in_bit = 1'b1;
    load(4'b1100, 1'b1, 1'b0);
    in_valid = 1'b0;
    send_bits(8'b0000_1100, 4); idle(2);
    chk("t6_matches", 32'(seen), 32'd1);

    // 7: clear coincident with a hit wins; all-ones Mealy pattern
    load(4'b1111, 1'b1, 1'b1); clr();
    send_bits(8'b0000_0111, 3);
    in_valid = 1'b1; in_bit = 1'b1; clear_cnt = 1'b1;
    cyc();
    clear_cnt = 1'b0; in_valid = 1'b0;
    chk("t7_clear_wins", 32'(ifa.match_count), 32'd0);
    send(1'b1);
    chk("t7_next_hit", 32'(ifa.match_count), 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
